// File: rtl/wf_samp_reader_pkg.sv
// Shared constants and prefetch FSM state encoding for the waveform sample reader.
package wf_samp_reader_pkg;

    localparam int unsigned WF_SAMP_ADDR_W = 13;
    localparam int unsigned WF_SAMP_W      = 16;
    localparam int unsigned WF_SAMP_OFS_W  = 12;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_WAIT  = 2'd2,
        ST_VALID = 2'd3
    } wf_samp_state_t;

endpackage

// File: rtl/wf_samp_prefetch.sv
// Prefetch FSM and sample hold register: fetches one {I,Q} word per start pulse.
// A start pulse in any state restarts the fetch, dropping any read in flight.
module wf_samp_prefetch
    import wf_samp_reader_pkg::*;
#(
    parameter int unsigned ADDR_W = WF_SAMP_ADDR_W,
    parameter int unsigned SAMP_W = WF_SAMP_W
) (
    input  logic                  cpu_clk,
    input  logic                  rst_n_C,
    input  logic                  i_start,
    input  logic [ADDR_W-1:0]     i_addr,
    input  logic [2*SAMP_W-1:0]   i_ram_data,
    output logic [ADDR_W-1:0]     o_ram_addr,
    output logic                  o_ram_rd,
    output logic [2*SAMP_W-1:0]   o_hold,
    output wf_samp_state_t        o_state
);

    wf_samp_state_t        r_state;
    wf_samp_state_t        w_state_next;
    logic [ADDR_W-1:0]     r_ram_addr;
    logic                  r_ram_rd;
    logic [2*SAMP_W-1:0]   r_hold;

    // State register
    always_ff @(posedge cpu_clk or negedge rst_n_C) begin
        if (!rst_n_C) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state: start wins everywhere, otherwise FETCH -> WAIT -> VALID
    always_comb begin
        w_state_next = r_state;
        if (i_start) begin
            w_state_next = ST_FETCH;
        end else begin
            case (r_state)
                ST_FETCH: w_state_next = ST_WAIT;
                ST_WAIT:  w_state_next = ST_VALID;
                default:  w_state_next = r_state;
            endcase
        end
    end

    // RAM request registers and hold capture; ram_rd is high exactly while in FETCH
    always_ff @(posedge cpu_clk or negedge rst_n_C) begin
        if (!rst_n_C) begin
            r_ram_addr <= '0;
            r_ram_rd   <= 1'b0;
            r_hold     <= '0;
        end else begin
            r_ram_rd <= (w_state_next == ST_FETCH);
            if (i_start) begin
                r_ram_addr <= i_addr;
            end
            if ((r_state == ST_WAIT) && !i_start) begin
                r_hold <= i_ram_data;
            end
        end
    end

    assign o_ram_addr = r_ram_addr;
    assign o_ram_rd   = r_ram_rd;
    assign o_hold     = r_hold;
    assign o_state    = r_state;

endmodule

// File: rtl/wf_samp_reader.sv
// CPU-side waveform sample reader: read pointer, strobe priority, sticky flags.
// Optional underrun detection enabled by defining WF_SAMP_READER_UNDERRUN_EN.
module wf_samp_reader
    import wf_samp_reader_pkg::*;
#(
    parameter int unsigned ADDR_W = WF_SAMP_ADDR_W,
    parameter int unsigned SAMP_W = WF_SAMP_W
) (
    input  logic                      cpu_clk,
    input  logic                      rst_n_C,
    input  logic                      rd_rst,
    input  logic                      rd_sync,
    input  logic                      rd_i,
    input  logic                      rd_q,
    input  logic [WF_SAMP_OFS_W-1:0]  rd_offset,
    input  logic [ADDR_W-1:0]         wr_addr,
    input  logic                      wr_continuous,
    output logic [ADDR_W-1:0]         ram_addr,
    output logic                      ram_rd,
    input  logic [2*SAMP_W-1:0]       ram_data,
    output logic [SAMP_W-1:0]         rd_iq,
    output logic                      rd_early,
    output logic                      rd_underrun
);

    logic [ADDR_W-1:0]     r_rp;
    logic [SAMP_W-1:0]     r_rd_iq;
    logic                  r_early;

    logic [ADDR_W-1:0]     w_ofs_ext;
    logic [ADDR_W-1:0]     w_rp_inc;
    logic [ADDR_W-1:0]     w_rp_next;
    logic                  w_start;
    logic                  w_advance;
    logic                  w_iq_load;
    logic [SAMP_W-1:0]     w_iq_next;
    logic                  w_early_set;
    logic                  w_flag_clr;
    logic                  w_valid;
    logic [2*SAMP_W-1:0]   w_hold;
    wf_samp_state_t        w_state;

    assign w_ofs_ext = ADDR_W'(rd_offset);
    assign w_rp_inc  = r_rp + ADDR_W'(1);
    assign w_valid   = (w_state == ST_VALID);

    // Strobe priority rd_rst > rd_sync > rd_i > rd_q; lower strobes are dropped
    always_comb begin
        w_start     = 1'b0;
        w_advance   = 1'b0;
        w_rp_next   = r_rp;
        w_iq_load   = 1'b0;
        w_iq_next   = r_rd_iq;
        w_early_set = 1'b0;
        w_flag_clr  = 1'b0;
        if (rd_rst) begin
            w_rp_next  = w_ofs_ext;
            w_start    = 1'b1;
            w_flag_clr = 1'b1;
        end else if (rd_sync) begin
            w_rp_next = wr_addr + w_ofs_ext;
            w_start   = 1'b1;
        end else if (rd_i) begin
            w_iq_load   = 1'b1;
            w_iq_next   = w_hold[2*SAMP_W-1:SAMP_W];
            w_early_set = !w_valid || rd_q;
        end else if (rd_q) begin
            w_iq_load = 1'b1;
            w_iq_next = w_hold[SAMP_W-1:0];
            if (w_valid) begin
                w_rp_next = w_rp_inc;
                w_start   = 1'b1;
                w_advance = 1'b1;
            end else begin
                w_early_set = 1'b1;
            end
        end
    end

    // Read pointer, returned sample half and early flag
    always_ff @(posedge cpu_clk or negedge rst_n_C) begin
        if (!rst_n_C) begin
            r_rp    <= '0;
            r_rd_iq <= '0;
            r_early <= 1'b0;
        end else begin
            r_rp <= w_rp_next;
            if (w_iq_load) begin
                r_rd_iq <= w_iq_next;
            end
            if (w_flag_clr) begin
                r_early <= 1'b0;
            end else if (w_early_set) begin
                r_early <= 1'b1;
            end
        end
    end

`ifdef WF_SAMP_READER_UNDERRUN_EN
    logic r_underrun;

    // Flag a ring-mode read that catches up with the writer
    always_ff @(posedge cpu_clk or negedge rst_n_C) begin
        if (!rst_n_C) begin
            r_underrun <= 1'b0;
        end else if (w_flag_clr) begin
            r_underrun <= 1'b0;
        end else if (w_advance && wr_continuous && (w_rp_inc == wr_addr)) begin
            r_underrun <= 1'b1;
        end
    end

    assign rd_underrun = r_underrun;
`else
    logic w_unused_cfg;
    assign w_unused_cfg = wr_continuous | w_advance;
    assign rd_underrun  = 1'b0;
`endif

    wf_samp_prefetch #(
        .ADDR_W (ADDR_W),
        .SAMP_W (SAMP_W)
    ) u_prefetch (
        .cpu_clk    (cpu_clk),
        .rst_n_C    (rst_n_C),
        .i_start    (w_start),
        .i_addr     (w_rp_next),
        .i_ram_data (ram_data),
        .o_ram_addr (ram_addr),
        .o_ram_rd   (ram_rd),
        .o_hold     (w_hold),
        .o_state    (w_state)
    );

    assign rd_iq    = r_rd_iq;
    assign rd_early = r_early;

endmodule

// File: tb/tb_wf_samp_reader.sv
// Bench for wf_samp_reader: directed scenarios plus random strobes against a
// cycle-level behavioural model of the reader.
module tb_wf_samp_reader;

    localparam int unsigned AW = 13;
    localparam int unsigned SW = 16;
    localparam int          N  = 1 << AW;

`ifdef WF_SAMP_READER_UNDERRUN_EN
    localparam bit UND_EN = 1'b1;
`else
    localparam bit UND_EN = 1'b0;
`endif

    logic          cpu_clk = 1'b0;
    logic          rst_n_C;
    logic          rd_rst, rd_sync, rd_i, rd_q;
    logic [11:0]   rd_offset;
    logic [AW-1:0] wr_addr;
    logic          wr_continuous;
    logic [AW-1:0] ram_addr;
    logic          ram_rd;
    logic [31:0]   ram_data;
    logic [SW-1:0] rd_iq;
    logic          rd_early, rd_underrun;

    logic [31:0]   mem [0:N-1];

    int total = 0;
    int bad   = 0;

    // model: m_cd = cycles until the fetched sample is held (-1 = never loaded)
    int            m_rp;
    int            m_cd;
    logic [31:0]   m_hold;
    logic [15:0]   m_iq;
    logic          m_early;
    logic          m_under;

    wf_samp_reader dut (
        .cpu_clk       (cpu_clk),
        .rst_n_C       (rst_n_C),
        .rd_rst        (rd_rst),
        .rd_sync       (rd_sync),
        .rd_i          (rd_i),
        .rd_q          (rd_q),
        .rd_offset     (rd_offset),
        .wr_addr       (wr_addr),
        .wr_continuous (wr_continuous),
        .ram_addr      (ram_addr),
        .ram_rd        (ram_rd),
        .ram_data      (ram_data),
        .rd_iq         (rd_iq),
        .rd_early      (rd_early),
        .rd_underrun   (rd_underrun)
    );

    always #5 cpu_clk = ~cpu_clk;

    // synchronous RAM, one cycle read latency
    always @(posedge cpu_clk) begin
        if (ram_rd) ram_data <= mem[ram_addr];
    end

    task automatic model_reset();
        m_rp = 0; m_cd = -1; m_hold = '0; m_iq = '0; m_early = 1'b0; m_under = 1'b0;
    endtask

    task automatic model_edge(input logic r, input logic s, input logic i, input logic q);
        bit valid;
        bit load;
        int newrp;
        valid = (m_cd == 0);
        load  = 1'b0;
        newrp = m_rp;
        if (r) begin
            newrp = int'(rd_offset); load = 1'b1; m_early = 1'b0; m_under = 1'b0;
        end else if (s) begin
            newrp = (int'(wr_addr) + int'(rd_offset)) % N; load = 1'b1;
        end else if (i) begin
            m_iq = m_hold[31:16];
            if (!valid || q) m_early = 1'b1;
        end else if (q) begin
            m_iq = m_hold[15:0];
            if (valid) begin
                newrp = (m_rp + 1) % N; load = 1'b1;
                if (UND_EN && wr_continuous && (newrp == int'(wr_addr))) m_under = 1'b1;
            end else begin
                m_early = 1'b1;
            end
        end
        if (load) begin
            m_rp = newrp; m_cd = 2;
        end else if (m_cd > 0) begin
            m_cd = m_cd - 1;
            if (m_cd == 0) m_hold = mem[m_rp];
        end
    endtask

    // apply one cycle of strobes; returns 1 ns after the edge
    task automatic step(input logic r, input logic s, input logic i, input logic q);
        rd_rst = r; rd_sync = s; rd_i = i; rd_q = q;
        @(posedge cpu_clk);
        if (!rst_n_C) model_reset();
        else model_edge(r, s, i, q);
        #1;
        rd_rst = 1'b0; rd_sync = 1'b0; rd_i = 1'b0; rd_q = 1'b0;
    endtask

    task automatic test_reset();
        rst_n_C = 1'b0;
        step(0, 0, 0, 0);
        step(1, 0, 1, 1);
        total++; if (ram_addr !== '0) begin bad++; $display("FAIL reset_ram_addr got=%0h exp=0", ram_addr); end
        total++; if (ram_rd !== 1'b0) begin bad++; $display("FAIL reset_ram_rd got=%b exp=0", ram_rd); end
        total++; if (rd_iq !== '0) begin bad++; $display("FAIL reset_rd_iq got=%0h exp=0", rd_iq); end
        total++; if (rd_early !== 1'b0 || rd_underrun !== 1'b0) begin
            bad++; $display("FAIL reset_flags got=%b%b exp=00", rd_early, rd_underrun); end
        rst_n_C = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step(0, 0, 0, 0);
            total++; if (ram_rd !== 1'b0) begin bad++; $display("FAIL idle_no_read cyc=%0d got=%b exp=0", k, ram_rd); end
        end
    endtask

    task automatic test_basic();
        mem[5] = 32'h1234_ABCD;
        rd_offset = 12'd5;
        step(1, 0, 0, 0);
        total++; if (ram_addr !== AW'(5) || ram_rd !== 1'b1) begin
            bad++; $display("FAIL basic_fetch got addr=%0h rd=%b exp addr=5 rd=1", ram_addr, ram_rd); end
        step(0, 0, 0, 0);
        total++; if (ram_rd !== 1'b0) begin bad++; $display("FAIL basic_rd_one_cycle got=%b exp=0", ram_rd); end
        step(0, 0, 0, 0);
        step(0, 0, 1, 0);
        total++; if (rd_iq !== 16'h1234 || rd_early !== 1'b0) begin
            bad++; $display("FAIL basic_rd_i got iq=%0h early=%b exp iq=1234 early=0", rd_iq, rd_early); end
        step(0, 0, 0, 1);
        total++; if (rd_iq !== 16'hABCD) begin bad++; $display("FAIL basic_rd_q got=%0h exp=abcd", rd_iq); end
        total++; if (ram_addr !== AW'(6) || ram_rd !== 1'b1) begin
            bad++; $display("FAIL basic_advance got addr=%0h rd=%b exp addr=6 rd=1", ram_addr, ram_rd); end
    endtask

    task automatic test_wrap_sync();
        wr_addr = AW'(8190); rd_offset = 12'd1;
        step(0, 1, 0, 0);
        total++; if (ram_addr !== AW'(8191)) begin bad++; $display("FAIL sync_to_top got=%0d exp=8191", ram_addr); end
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        step(0, 0, 0, 1);
        total++; if (ram_addr !== AW'(0) || ram_rd !== 1'b1) begin
            bad++; $display("FAIL wrap got addr=%0d rd=%b exp addr=0 rd=1", ram_addr, ram_rd); end
        rd_offset = 12'd4;
        step(0, 1, 0, 0);
        total++; if (ram_addr !== AW'(2)) begin bad++; $display("FAIL sync_mod got=%0d exp=2", ram_addr); end
        rd_offset = 12'd7;
        step(1, 1, 0, 0);
        total++; if (ram_addr !== AW'(7)) begin bad++; $display("FAIL rst_over_sync got=%0d exp=7", ram_addr); end
    endtask

    task automatic test_early();
        mem[20] = 32'hC0DE_5A5A;
        mem[21] = 32'h7777_8888;
        rd_offset = 12'd20;
        step(1, 0, 0, 0);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        step(0, 0, 1, 0);
        step(0, 0, 0, 1);
        total++; if (rd_iq !== 16'h5A5A || rd_early !== 1'b0) begin
            bad++; $display("FAIL early_pre got iq=%0h early=%b exp iq=5a5a early=0", rd_iq, rd_early); end
        step(0, 0, 1, 0);
        total++; if (rd_early !== 1'b1 || rd_iq !== 16'hC0DE) begin
            bad++; $display("FAIL early_set got early=%b iq=%0h exp early=1 iq=c0de", rd_early, rd_iq); end
        step(1, 0, 0, 0);
        total++; if (rd_early !== 1'b0) begin bad++; $display("FAIL early_clear got=%b exp=0", rd_early); end
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        step(0, 0, 1, 1);
        total++; if (rd_early !== 1'b1 || rd_iq !== 16'hC0DE || ram_rd !== 1'b0) begin
            bad++; $display("FAIL i_and_q got early=%b iq=%0h rd=%b exp early=1 iq=c0de rd=0", rd_early, rd_iq, ram_rd); end
    endtask

    task automatic test_underrun();
        wr_continuous = 1'b1; wr_addr = AW'(100); rd_offset = 12'd99;
        step(1, 0, 0, 0);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        step(0, 0, 0, 1);
        total++; if (rd_underrun !== UND_EN) begin bad++; $display("FAIL underrun_set got=%b exp=%b", rd_underrun, UND_EN); end
        total++; if (ram_addr !== AW'(100)) begin bad++; $display("FAIL underrun_advance got=%0d exp=100", ram_addr); end
        step(1, 0, 0, 0);
        total++; if (rd_underrun !== 1'b0) begin bad++; $display("FAIL underrun_clear got=%b exp=0", rd_underrun); end
        wr_continuous = 1'b0;
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        step(0, 0, 0, 1);
        total++; if (rd_underrun !== 1'b0) begin bad++; $display("FAIL underrun_oneshot got=%b exp=0", rd_underrun); end
    endtask

    task automatic test_async_reset();
        rd_offset = 12'd33;
        step(1, 0, 0, 0);
        step(0, 0, 1, 0);
        #3;
        rst_n_C = 1'b0;
        #1;
        total++; if (ram_addr !== '0 || ram_rd !== 1'b0 || rd_iq !== '0 || rd_early !== 1'b0 || rd_underrun !== 1'b0) begin
            bad++; $display("FAIL async_reset got addr=%0h rd=%b iq=%0h early=%b under=%b exp all 0",
                            ram_addr, ram_rd, rd_iq, rd_early, rd_underrun); end
        model_reset();
        step(0, 0, 0, 0);
        rst_n_C = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step(0, 0, 0, 0);
            total++; if (ram_rd !== 1'b0) begin bad++; $display("FAIL post_reset_no_read cyc=%0d got=%b exp=0", k, ram_rd); end
        end
        step(0, 0, 1, 0);
        total++; if (rd_iq !== '0 || rd_early !== 1'b1) begin
            bad++; $display("FAIL post_reset_early got iq=%0h early=%b exp iq=0 early=1", rd_iq, rd_early); end
        step(1, 0, 0, 0);
        total++; if (ram_rd !== 1'b1 || ram_addr !== AW'(33)) begin
            bad++; $display("FAIL post_reset_fetch got addr=%0d rd=%b exp addr=33 rd=1", ram_addr, ram_rd); end
    endtask

    task automatic test_random();
        logic r, s, i, q;
        for (int c = 0; c < 800; c++) begin
            r = ($urandom_range(0, 39) == 0);
            s = ($urandom_range(0, 39) == 0);
            i = ($urandom_range(0, 3) == 0);
            q = ($urandom_range(0, 2) == 0);
            rd_offset     = 12'($urandom);
            wr_continuous = 1'($urandom);
            if ($urandom_range(0, 3) == 0) wr_addr = AW'((m_rp + 1) % N);
            else wr_addr = AW'($urandom);
            step(r, s, i, q);
            total++; if (ram_addr !== AW'(m_rp)) begin
                bad++; $display("FAIL rnd_ram_addr cyc=%0d got=%0d exp=%0d", c, ram_addr, m_rp); end
            total++; if (ram_rd !== (m_cd == 2)) begin
                bad++; $display("FAIL rnd_ram_rd cyc=%0d got=%b exp=%b", c, ram_rd, (m_cd == 2)); end
            total++; if (rd_iq !== m_iq) begin
                bad++; $display("FAIL rnd_rd_iq cyc=%0d got=%0h exp=%0h", c, rd_iq, m_iq); end
            total++; if (rd_early !== m_early) begin
                bad++; $display("FAIL rnd_rd_early cyc=%0d got=%b exp=%b", c, rd_early, m_early); end
            total++; if (rd_underrun !== m_under) begin
                bad++; $display("FAIL rnd_rd_underrun cyc=%0d got=%b exp=%b", c, rd_underrun, m_under); end
        end
    endtask

    initial begin
        for (int a = 0; a < N; a++) mem[a] = $urandom;
        rst_n_C = 1'b0;
        rd_rst = 1'b0; rd_sync = 1'b0; rd_i = 1'b0; rd_q = 1'b0;
        rd_offset = '0; wr_addr = '0; wr_continuous = 1'b0;
        ram_data = '0;
        model_reset();
        #2;
        test_reset();
        test_basic();
        test_wrap_sync();
        test_early();
        test_underrun();
        test_async_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
